serial_2_parallel_master: RTL

SPI master receiver that clocks 16-bit words in from an SPI slave and presents them as parallel data.
- It drives SCK and chip select from the FPGA system clock.
- It samples MISO MSB first and emits each completed word with a one-cycle valid strobe.
- It is the reading end of the 16-bit, negedge-shifting, MSB-first SPI link used in the filter data path, for on-chip loopback and for sensor front-ends using the same framing.

---
 rtl/serial_2_parallel_master.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/serial_2_parallel_master.sv
// SPI master receiver: clocks DATA_W-bit MSB-first words in from a slave and presents them in parallel.
// Optional data_stale flag (all-zero word indicator) is enabled by defining S2P_STALE_FLAG_EN.
module serial_2_parallel_master #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              spi_sck,
  output logic              spi_cs_n,
  input  logic              spi_miso,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid
`ifdef S2P_STALE_FLAG_EN
  ,
  output logic              data_stale
`endif
);

  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SCK_LO,
    SCK_HI,
    TRAIL,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              div_done;

  logic              cs_n_d, sck_d, busy_d, valid_d;
  logic [DATA_W-1:0] data_d;
`ifdef S2P_STALE_FLAG_EN
  logic              stale_d;
`endif

  // State, counters and all output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      spi_cs_n   <= 1'b1;
      spi_sck    <= 1'b1;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
`ifdef S2P_STALE_FLAG_EN
      data_stale <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      spi_cs_n   <= cs_n_d;
      spi_sck    <= sck_d;
      busy       <= busy_d;
      data_valid <= valid_d;
      data_out   <= data_d;
`ifdef S2P_STALE_FLAG_EN
      data_stale <= stale_d;
`endif
    end
  end

  assign div_done = (div_q == DIV_W'(CLK_DIV - 1));

  // Next-state, counter and shift logic; every transition clears the divider
  always_comb begin
    state_d = state_q;
    div_d   = div_q + DIV_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        div_d = '0;
        if (start) begin
          state_d = LEAD;
          bit_d   = '0;
        end
      end
      LEAD: begin
        if (div_done) begin
          state_d = SCK_LO;
          div_d   = '0;
        end
      end
      SCK_LO: begin
        if (div_done) begin
          state_d = SCK_HI;
          div_d   = '0;
        end
      end
      SCK_HI: begin
        if (div_done) begin
          shift_d = {shift_q[DATA_W-2:0], spi_miso};
          bit_d   = bit_q + BIT_W'(1);
          div_d   = '0;
          state_d = (bit_q == BIT_W'(DATA_W - 1)) ? TRAIL : SCK_LO;
        end
      end
      TRAIL: begin
        if (div_done) begin
          state_d = GAP;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      GAP: begin
        if (div_done) begin
          state_d = IDLE;
          div_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Outputs follow the state one cycle later, so spi_cs_n falls the cycle after LEAD is entered
  always_comb begin
    cs_n_d  = (state_q == IDLE) || (state_q == GAP);
    sck_d   = (state_q != SCK_LO);
    busy_d  = (state_q != IDLE);
    valid_d = (state_q == GAP) && (div_q == DIV_W'(0));
    data_d  = valid_d ? shift_q : data_out;
`ifdef S2P_STALE_FLAG_EN
    stale_d = valid_d ? (shift_q == '0) : data_stale;
`endif
  end

endmodule
